// File: rtl/usb_fifo_pkg.sv
// ---------------------------------------------------------------------------
// usb_fifo_pkg
// Shared definitions for the USB endpoint FIFOs.
//   DEF_DATA_W / DEF_DEPTH : default word width and depth reused by endpoint FIFOs
//   clog2()                : elaboration-time ceiling log2 for sizing pointers
//   ptr_dist()             : distance between two wrap-bit pointers of width aw+1
// ---------------------------------------------------------------------------
package usb_fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 64;

  // Ceiling log2, used at elaboration time to size address and pointer fields.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Pointers carry one extra wrap bit, so plain subtraction masked to aw+1 bits
  // yields the occupancy between them, including the completely-full case.
  function automatic int unsigned ptr_dist(input int unsigned head,
                                           input int unsigned tail,
                                           input int aw);
    int unsigned mask;
    mask = (32'd1 << (aw + 1)) - 32'd1;
    return (head - tail) & mask;
  endfunction

endpackage

// File: rtl/usb_pkt_fifo_if.sv
// ---------------------------------------------------------------------------
// usb_pkt_fifo_if
// Handshake bundle between the USB packet receiver / endpoint logic (master)
// and the packet FIFO (slave).
//   flush                         : synchronous clear of contents and flags
//   wr_valid/wr_ready/wr_data     : write stream
//   wr_commit/wr_discard          : publish or drop the pending packet
//   rd_valid/rd_ready/rd_data     : read stream, first-word fall-through
//   level/almost_full/overflow    : status
// ---------------------------------------------------------------------------
interface usb_pkt_fifo_if #(
  parameter int DATA_W = usb_fifo_pkg::DEF_DATA_W,
  parameter int DEPTH  = usb_fifo_pkg::DEF_DEPTH
);
  localparam int AW = usb_fifo_pkg::clog2(DEPTH);

  logic              flush;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              wr_commit;
  logic              wr_discard;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic [AW:0]       level;
  logic              almost_full;
  logic              overflow;

  modport master (
    output flush, wr_valid, wr_data, wr_commit, wr_discard, rd_ready,
    input  wr_ready, rd_valid, rd_data, level, almost_full, overflow
  );

  modport slave (
    input  flush, wr_valid, wr_data, wr_commit, wr_discard, rd_ready,
    output wr_ready, rd_valid, rd_data, level, almost_full, overflow
  );

endinterface

// File: rtl/usb_fifo_ram.sv
// ---------------------------------------------------------------------------
// usb_fifo_ram
// DEPTH x DATA_W storage with one synchronous write port and one asynchronous
// read port. Storage is deliberately not reset; validity is tracked by the
// pointers in the owning FIFO.
//   clk      : write clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : read data (combinational)
// ---------------------------------------------------------------------------
module usb_fifo_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64,
  parameter int AW     = 6
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Plain clocked write; no reset so the array maps onto RAM cells.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Asynchronous read gives the FIFO its first-word fall-through behaviour.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/usb_pkt_fifo.sv
// ---------------------------------------------------------------------------
// usb_pkt_fifo
// Single-clock packet FIFO for USB endpoint buffering. Bytes are written
// speculatively behind a commit pointer; the reader only sees data up to the
// commit pointer, and a discard rewinds the write pointer to drop the pending
// packet whole.
//   clk    : clock, all state on rising edge
//   rst_n  : asynchronous reset, active low
//   bus    : usb_pkt_fifo_if.slave (write/read handshakes, commit/discard,
//            flush, level, almost_full, sticky overflow)
// ---------------------------------------------------------------------------
module usb_pkt_fifo
  import usb_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AF_LVL = 56
) (
  input logic           clk,
  input logic           rst_n,
  usb_pkt_fifo_if.slave bus
);

  localparam int AW = clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] cmt_ptr_q, cmt_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        overflow_q, overflow_d;

  logic        full;
  logic        wr_fire;
  logic        rd_fire;
  logic        ram_we;
  logic [AW:0] wr_ptr_next;
  logic [AW:0] used;

  // Full includes uncommitted words and depends only on registered pointers,
  // so a read in the same cycle never opens room for a write.
  assign full        = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign wr_fire     = bus.wr_valid && !full;
  assign rd_fire     = bus.rd_valid && bus.rd_ready;
  assign wr_ptr_next = wr_ptr_q + {{AW{1'b0}}, wr_fire};
  assign ram_we      = wr_fire && !bus.flush && !bus.wr_discard;

  // Next-state pointers. Flush overrides everything; discard beats commit and
  // also swallows a word written in the same cycle. A write attempt while full
  // still marks overflow even if the packet is being discarded.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    cmt_ptr_d  = cmt_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (bus.flush) begin
      wr_ptr_d   = '0;
      cmt_ptr_d  = '0;
      rd_ptr_d   = '0;
      overflow_d = 1'b0;
    end else begin
      if (bus.wr_discard) begin
        wr_ptr_d = cmt_ptr_q;
      end else begin
        wr_ptr_d = wr_ptr_next;
        if (bus.wr_commit) begin
          cmt_ptr_d = wr_ptr_next;
        end
      end
      if (rd_fire) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (bus.wr_valid && full) begin
        overflow_d = 1'b1;
      end
    end
  end

  // Pointer and flag registers; an asynchronous reset empties the FIFO at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      cmt_ptr_q  <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      cmt_ptr_q  <= cmt_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  usb_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (bus.wr_data),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (bus.rd_data)
  );

  // Status outputs are pure functions of the registered pointers, so a word
  // becomes readable only the cycle after its commit edge.
  assign used            = PW'(ptr_dist(32'(wr_ptr_q), 32'(rd_ptr_q), AW));
  assign bus.level       = PW'(ptr_dist(32'(cmt_ptr_q), 32'(rd_ptr_q), AW));
  assign bus.rd_valid    = (cmt_ptr_q != rd_ptr_q);
  assign bus.wr_ready    = !full;
  assign bus.almost_full = (used >= PW'(AF_LVL));
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_usb_pkt_fifo.sv
// ---------------------------------------------------------------------------
// tb_usb_pkt_fifo
// Self-checking bench for usb_pkt_fifo (DATA_W=8, DEPTH=8, AF_LVL=6).
// A queue-based packet model (committed queue + pending queue) predicts every
// output each cycle; a vector table and hand-written sequences add fixed
// expectations for the scenario corners; a random phase closes it out.
// ---------------------------------------------------------------------------
module tb_usb_pkt_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int AF_LVL = 6;

  logic clk;
  logic rst_n;

  usb_pkt_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  usb_pkt_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AF_LVL (AF_LVL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       wv;
    logic [7:0] wd;
    logic       wc;
    logic       wdisc;
    logic       rr;
    logic       fl;
    int         expLevel;
    logic       expRv;
    logic       expWr;
    logic       expAf;
    logic       expOv;
    logic [7:0] expData;
  } vecT;

  vecT vecs[$];

  byte unsigned cmtQ[$];
  byte unsigned pendQ[$];
  bit           modelOv;

  int checkCount;
  int errCount;

  // Single comparison point: every check bumps checkCount, every miss errCount.
  task automatic cmpVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Packet-level reference: reads pop committed bytes, accepted writes go to the
  // pending packet, discard empties it, commit moves it onto the committed queue.
  task automatic modelStep(input logic wv, input logic [7:0] wd, input logic wc,
                           input logic wdisc, input logic rr, input logic fl);
    int used;
    if (fl) begin
      cmtQ.delete();
      pendQ.delete();
      modelOv = 1'b0;
    end else begin
      used = cmtQ.size() + pendQ.size();
      if (wv && used == DEPTH) modelOv = 1'b1;
      if (rr && cmtQ.size() > 0) void'(cmtQ.pop_front());
      if (wv && used < DEPTH) pendQ.push_back(wd);
      if (wdisc) begin
        pendQ.delete();
      end else if (wc) begin
        foreach (pendQ[i]) cmtQ.push_back(pendQ[i]);
        pendQ.delete();
      end
    end
  endtask

  task automatic modelReset();
    cmtQ.delete();
    pendQ.delete();
    modelOv = 1'b0;
  endtask

  // Compares all outputs against the reference model.
  task automatic checkOutput(input string tag);
    int used;
    used = cmtQ.size() + pendQ.size();
    cmpVal({tag, ".wr_ready"},    32'(bus.wr_ready),    32'(used < DEPTH));
    cmpVal({tag, ".rd_valid"},    32'(bus.rd_valid),    32'(cmtQ.size() > 0));
    cmpVal({tag, ".level"},       32'(bus.level),       32'(cmtQ.size()));
    cmpVal({tag, ".almost_full"}, 32'(bus.almost_full), 32'(used >= AF_LVL));
    cmpVal({tag, ".overflow"},    32'(bus.overflow),    32'(modelOv));
    if (cmtQ.size() > 0) cmpVal({tag, ".rd_data"}, 32'(bus.rd_data), 32'(cmtQ[0]));
  endtask

  // Called just after a falling edge: drive inputs, clock once, then check.
  task automatic applyStimulus(input string tag, input logic wv, input logic [7:0] wd,
                               input logic wc, input logic wdisc, input logic rr,
                               input logic fl);
    bus.wr_valid   = wv;
    bus.wr_data    = wd;
    bus.wr_commit  = wc;
    bus.wr_discard = wdisc;
    bus.rd_ready   = rr;
    bus.flush      = fl;
    @(posedge clk);
    modelStep(wv, wd, wc, wdisc, rr, fl);
    @(negedge clk);
    checkOutput(tag);
  endtask

  task automatic idleInputs();
    bus.wr_valid   = 1'b0;
    bus.wr_data    = '0;
    bus.wr_commit  = 1'b0;
    bus.wr_discard = 1'b0;
    bus.rd_ready   = 1'b0;
    bus.flush      = 1'b0;
  endtask

  function automatic vecT mkVec(input logic wv, input logic [7:0] wd, input logic wc,
                                input logic wdisc, input logic rr, input int lvl,
                                input logic rv, input logic wr, input logic af,
                                input logic ov, input logic [7:0] d);
    vecT v;
    v.wv = wv; v.wd = wd; v.wc = wc; v.wdisc = wdisc; v.rr = rr; v.fl = 1'b0;
    v.expLevel = lvl; v.expRv = rv; v.expWr = wr; v.expAf = af; v.expOv = ov;
    v.expData = d;
    return v;
  endfunction

  initial begin
    checkCount = 0;
    errCount   = 0;
    modelReset();
    idleInputs();
    rst_n = 1'b0;

    // Packet 1..5 committed on the last write, then drained.
    //                 wv  wd  wc wdis rr  lvl rv wr af ov data
    vecs.push_back(mkVec(1, 1, 0, 0, 0,  0, 0, 1, 0, 0, 0));
    vecs.push_back(mkVec(1, 2, 0, 0, 0,  0, 0, 1, 0, 0, 0));
    vecs.push_back(mkVec(1, 3, 0, 0, 0,  0, 0, 1, 0, 0, 0));
    vecs.push_back(mkVec(1, 4, 0, 0, 0,  0, 0, 1, 0, 0, 0));
    vecs.push_back(mkVec(1, 5, 1, 0, 0,  5, 1, 1, 0, 0, 1));
    vecs.push_back(mkVec(0, 0, 0, 0, 1,  4, 1, 1, 0, 0, 2));
    vecs.push_back(mkVec(0, 0, 0, 0, 1,  3, 1, 1, 0, 0, 3));
    vecs.push_back(mkVec(0, 0, 0, 0, 1,  2, 1, 1, 0, 0, 4));
    vecs.push_back(mkVec(0, 0, 0, 0, 1,  1, 1, 1, 0, 0, 5));
    vecs.push_back(mkVec(0, 0, 0, 0, 1,  0, 0, 1, 0, 0, 0));
    // Commit 1..3, discard 4..6 (discard on the 6th), then packet 7.
    vecs.push_back(mkVec(1, 1, 0, 0, 0,  0, 0, 1, 0, 0, 0));
    vecs.push_back(mkVec(1, 2, 0, 0, 0,  0, 0, 1, 0, 0, 0));
    vecs.push_back(mkVec(1, 3, 1, 0, 0,  3, 1, 1, 0, 0, 1));
    vecs.push_back(mkVec(1, 4, 0, 0, 0,  3, 1, 1, 0, 0, 1));
    vecs.push_back(mkVec(1, 5, 0, 0, 0,  3, 1, 1, 0, 0, 1));
    vecs.push_back(mkVec(1, 6, 0, 1, 0,  3, 1, 1, 0, 0, 1));
    vecs.push_back(mkVec(0, 0, 0, 0, 1,  2, 1, 1, 0, 0, 2));
    vecs.push_back(mkVec(0, 0, 0, 0, 1,  1, 1, 1, 0, 0, 3));
    vecs.push_back(mkVec(0, 0, 0, 0, 1,  0, 0, 1, 0, 0, 0));
    vecs.push_back(mkVec(1, 7, 1, 0, 0,  1, 1, 1, 0, 0, 7));
    vecs.push_back(mkVec(0, 0, 0, 0, 1,  0, 0, 1, 0, 0, 0));

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checkOutput("reset");
    cmpVal("reset.wr_ready_const", 32'(bus.wr_ready), 32'd1);
    cmpVal("reset.rd_valid_const", 32'(bus.rd_valid), 32'd0);
    cmpVal("reset.level_const",    32'(bus.level),    32'd0);

    foreach (vecs[i]) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].wv, vecs[i].wd, vecs[i].wc,
                    vecs[i].wdisc, vecs[i].rr, vecs[i].fl);
      cmpVal($sformatf("vec%0d.level", i),       32'(bus.level),       32'(vecs[i].expLevel));
      cmpVal($sformatf("vec%0d.rd_valid", i),    32'(bus.rd_valid),    32'(vecs[i].expRv));
      cmpVal($sformatf("vec%0d.wr_ready", i),    32'(bus.wr_ready),    32'(vecs[i].expWr));
      cmpVal($sformatf("vec%0d.almost_full", i), 32'(bus.almost_full), 32'(vecs[i].expAf));
      cmpVal($sformatf("vec%0d.overflow", i),    32'(bus.overflow),    32'(vecs[i].expOv));
      if (vecs[i].expRv)
        cmpVal($sformatf("vec%0d.rd_data", i), 32'(bus.rd_data), 32'(vecs[i].expData));
    end

    // Fill all 8 entries uncommitted, overflow on the 9th, commit, drain 0..7.
    for (int i = 0; i < DEPTH; i++) applyStimulus("fill", 1, 8'(i), 0, 0, 0, 0);
    cmpVal("fill.wr_ready",    32'(bus.wr_ready),    32'd0);
    cmpVal("fill.rd_valid",    32'(bus.rd_valid),    32'd0);
    cmpVal("fill.almost_full", 32'(bus.almost_full), 32'd1);
    applyStimulus("ovf", 1, 8'd99, 0, 0, 0, 0);
    cmpVal("ovf.overflow", 32'(bus.overflow), 32'd1);
    applyStimulus("fillcommit", 0, 0, 1, 0, 0, 0);
    cmpVal("fillcommit.level", 32'(bus.level), 32'd8);
    for (int i = 0; i < DEPTH; i++) begin
      cmpVal($sformatf("drain%0d.rd_data", i), 32'(bus.rd_data), 32'(i));
      applyStimulus("drain", 0, 0, 0, 0, 1, 0);
    end

    // Three write-5/commit/read-5 rounds starting mid-buffer so pointers wrap.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 5; k++)
        applyStimulus("wrapw", 1, 8'(8'h40 + r * 8 + k), (k == 4) ? 1'b1 : 1'b0, 0, 0, 0);
      for (int k = 0; k < 5; k++) begin
        cmpVal("wrap.rd_data", 32'(bus.rd_data), 32'(8'h40 + r * 8 + k));
        applyStimulus("wrapr", 0, 0, 0, 0, 1, 0);
      end
      cmpVal("wrap.level", 32'(bus.level), 32'd0);
    end

    // Commit and discard together: discard wins, nothing becomes visible.
    for (int k = 0; k < 4; k++)
      applyStimulus("cd", 1, 8'(8'h70 + k), (k == 3) ? 1'b1 : 1'b0, (k == 3) ? 1'b1 : 1'b0, 0, 0);
    cmpVal("cd.level",    32'(bus.level),    32'd0);
    cmpVal("cd.wr_ready", 32'(bus.wr_ready), 32'd1);
    // Flush with three committed words and a sticky overflow still set.
    for (int k = 0; k < 3; k++)
      applyStimulus("pref", 1, 8'(8'h80 + k), (k == 2) ? 1'b1 : 1'b0, 0, 0, 0);
    cmpVal("pref.level", 32'(bus.level), 32'd3);
    applyStimulus("flush", 1, 8'h90, 1, 0, 1, 1);
    cmpVal("flush.level",    32'(bus.level),    32'd0);
    cmpVal("flush.overflow", 32'(bus.overflow), 32'd0);

    // Asynchronous reset mid-read with four words readable.
    for (int k = 0; k < 5; k++)
      applyStimulus("prer", 1, 8'(8'hA0 + k), (k == 4) ? 1'b1 : 1'b0, 0, 0, 0);
    applyStimulus("prer", 0, 0, 0, 0, 1, 0);
    cmpVal("prer.level", 32'(bus.level), 32'd4);
    bus.rd_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    cmpVal("areset.rd_valid", 32'(bus.rd_valid), 32'd0);
    cmpVal("areset.level",    32'(bus.level),    32'd0);
    modelReset();
    idleInputs();
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("areset.release");

    // Random traffic against the packet model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus("rand",
                    ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
                    8'($urandom),
                    ($urandom_range(0, 19) < 3) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 9) < 5) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0);
    end

    $display("test done: total=%0d bad=%0d", checkCount, errCount);
    $finish;
  end

endmodule
